// File: rtl/crc_serial_engine.sv
// Serial CRC engine for the USB bit datapath: generate mode passes data through and appends
// the complemented CRC, check mode consumes data plus CRC and compares against the residue.
module crc_serial_engine #(
    parameter int               CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(16'h8005),
    parameter logic [CRC_W-1:0] INIT      = '1,
    parameter logic [CRC_W-1:0] RESIDUE   = CRC_W'(16'h800D),
    parameter int               SKIP_BITS = 8,
    parameter int               CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode_check,
    input  logic             pkt_start,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [CNT_W-1:0] bit_count
);
    localparam int               IDX_W    = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] SKIP_C   = CNT_W'(SKIP_BITS);
    localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(SKIP_BITS + CRC_W);

    typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;

    state_t           state, state_n;
    logic             mode_q;
    logic [CRC_W-1:0] crc, crc_step, crc_next;
    logic [IDX_W-1:0] flush_idx;
    logic [CNT_W-1:0] cnt_next;
    logic             accept, fb, chk_good;

    // Datapath: next register and count as they will look after this cycle's accepted bit.
    always_comb begin
        accept   = in_valid & in_ready;
        fb       = in_bit ^ crc[CRC_W-1];
        crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        crc_next = (accept && bit_count >= SKIP_C) ? crc_step : crc;
        cnt_next = (accept && bit_count != '1) ? bit_count + CNT_W'(1) : bit_count;
        // Evaluated on the final bit so the verdict is already valid while done is high.
        chk_good = (crc_next == RESIDUE) && (cnt_next >= MIN_BITS);
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: ;
            CALC: begin
                if (mode_q) begin
                    in_ready = 1'b1;
                end else begin
                    in_ready  = out_ready;
                    out_valid = in_valid;
                    out_bit   = in_bit;
                end
                if (in_valid && in_ready && in_last)
                    state_n = mode_q ? DONE : FLUSH;
            end
            FLUSH: begin
                out_valid = 1'b1;
                out_bit   = ~crc[IDX_LAST - flush_idx];
                if (out_ready && flush_idx == IDX_LAST)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A new packet aborts whatever is in flight, including a coincident last bit.
        if (pkt_start)
            state_n = CALC;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            crc       <= INIT;
            bit_count <= '0;
            flush_idx <= '0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (pkt_start) begin
                mode_q    <= mode_check;
                crc       <= INIT;
                bit_count <= '0;
                flush_idx <= '0;
                crc_ok    <= 1'b0;
                crc_err   <= 1'b0;
            end else begin
                crc       <= crc_next;
                bit_count <= cnt_next;
                if (state == CALC && accept && in_last) begin
                    flush_idx <= '0;
                    if (mode_q) begin
                        crc_ok  <= chk_good;
                        crc_err <= ~chk_good;
                    end
                end
                if (state == FLUSH && out_ready)
                    flush_idx <= flush_idx + IDX_W'(1);
            end
        end
    end
endmodule
